// File: rtl/buff_sequencer.sv
// Burst sequencer for a shared circular buffer: admits fixed-length write/read
// bursts against the tracked occupancy and emits the controller toggle pairs.
module buff_sequencer #(
    parameter int SIZE  = 64,
    parameter int BURST = 16,
    parameter int LVLW  = $clog2(SIZE + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_req,
    input  logic            rd_req,
    output logic            wr_toggle,
    output logic            rd_toggle,
    output logic            wr_strobe,
    output logic            rd_strobe,
    output logic            wr_busy,
    output logic            rd_busy,
    output logic            wr_done,
    output logic            rd_done,
    output logic            wr_err,
    output logic            rd_err,
    output logic [LVLW-1:0] level,
    output logic            dbg_wr_state,
    output logic            dbg_rd_state
);

    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [CW-1:0]   LAST   = CW'(BURST - 1);
    localparam logic [LVLW-1:0] WR_MAX = LVLW'(SIZE - BURST);
    localparam logic [LVLW-1:0] RD_MIN = LVLW'(BURST);

    logic [0:0]      wr_state_q, wr_state_d;
    logic [0:0]      rd_state_q, rd_state_d;
    logic [CW-1:0]   wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]   rd_cnt_q, rd_cnt_d;
    logic            wr_done_q, wr_done_d;
    logic            rd_done_q, rd_done_d;
    logic            wr_err_q, wr_err_d;
    logic            rd_err_q, rd_err_d;
    logic [LVLW-1:0] level_q, level_d;
    logic            wr_beat, rd_beat;

    assign wr_beat = (wr_state_q == S_RUN);
    assign rd_beat = (rd_state_q == S_RUN);

    // Handshake: a request is sampled every cycle; it is accepted only from IDLE
    // with room/data available, otherwise it yields a one-cycle *_err pulse.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_cnt_d   = wr_cnt_q;
        wr_done_d  = 1'b0;
        wr_err_d   = 1'b0;
        case (wr_state_q)
            S_IDLE: begin
                if (wr_req) begin
                    if (level_q <= WR_MAX) begin
                        wr_state_d = S_RUN;
                        wr_cnt_d   = '0;
                    end else begin
                        wr_err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                wr_err_d = wr_req;
                if (wr_cnt_q == LAST) begin
                    wr_state_d = S_IDLE;
                    wr_cnt_d   = '0;
                    wr_done_d  = 1'b1;
                end else begin
                    wr_cnt_d = wr_cnt_q + 1'b1;
                end
            end
            default: wr_state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_cnt_d   = rd_cnt_q;
        rd_done_d  = 1'b0;
        rd_err_d   = 1'b0;
        case (rd_state_q)
            S_IDLE: begin
                if (rd_req) begin
                    if (level_q >= RD_MIN) begin
                        rd_state_d = S_RUN;
                        rd_cnt_d   = '0;
                    end else begin
                        rd_err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                rd_err_d = rd_req;
                if (rd_cnt_q == LAST) begin
                    rd_state_d = S_IDLE;
                    rd_cnt_d   = '0;
                    rd_done_d  = 1'b1;
                end else begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end
            default: rd_state_d = S_IDLE;
        endcase
    end

    // Coincident write and read beats cancel out in the occupancy count.
    always_comb begin
        level_d = level_q;
        case ({wr_beat, rd_beat})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_state_q <= S_IDLE;
            rd_state_q <= S_IDLE;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            wr_done_q  <= 1'b0;
            rd_done_q  <= 1'b0;
            wr_err_q   <= 1'b0;
            rd_err_q   <= 1'b0;
            level_q    <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_done_q  <= wr_done_d;
            rd_done_q  <= rd_done_d;
            wr_err_q   <= wr_err_d;
            rd_err_q   <= rd_err_d;
            level_q    <= level_d;
        end
    end

    assign wr_strobe    = wr_beat;
    assign rd_strobe    = rd_beat;
    assign wr_busy      = wr_beat;
    assign rd_busy      = rd_beat;
    assign wr_toggle    = wr_beat && ((wr_cnt_q == '0) || (wr_cnt_q == LAST));
    assign rd_toggle    = rd_beat && ((rd_cnt_q == '0) || (rd_cnt_q == LAST));
    assign wr_done      = wr_done_q;
    assign rd_done      = rd_done_q;
    assign wr_err       = wr_err_q;
    assign rd_err       = rd_err_q;
    assign level        = level_q;
    assign dbg_wr_state = wr_state_q[0];
    assign dbg_rd_state = rd_state_q[0];

endmodule
